// File: rtl/score_bcd_accumulator.sv
// Tetris score keeper: adds level-scaled line-clear points to a 4-digit packed-BCD
// score, one digit per clock, publishing the score only once the whole sum is done.
module score_bcd_accumulator #(
    parameter logic [7:0] PTS_1 = 8'h01,
    parameter logic [7:0] PTS_2 = 8'h03,
    parameter logic [7:0] PTS_3 = 8'h05,
    parameter logic [7:0] PTS_4 = 8'h08
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        event_valid,
    output logic        event_ready,
    input  logic [2:0]  clear_count,
    input  logic [3:0]  level,
    input  logic        clear_score,
    output logic [15:0] score_bcd,
    output logic        score_update,
    output logic        saturated
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] acc;
    logic [7:0]  pts;
    logic [3:0]  rep;
    logic [1:0]  dig;
    logic        carry;

    logic        accept;
    logic [7:0]  ev_pts;
    logic        skip_add;
    logic [3:0]  acc_dig, pts_dig, sum_dig;
    logic [4:0]  s, s_minus10;
    logic        carry_out;
    logic [15:0] acc_add;
    logic        last_dig;

    always_comb begin
        case (clear_count)
            3'd1:    ev_pts = PTS_1;
            3'd2:    ev_pts = PTS_2;
            3'd3:    ev_pts = PTS_3;
            3'd4:    ev_pts = PTS_4;
            default: ev_pts = 8'h00;
        endcase
    end

    // clear_score wins over a simultaneous handshake
    assign accept   = event_valid && event_ready && !clear_score;
    assign skip_add = (ev_pts == 8'h00) || saturated;
    assign last_dig = (dig == 2'd3);

    // single BCD digit adder, steered to digit dig
    always_comb begin
        acc_dig   = acc[{dig, 2'b00} +: 4];
        pts_dig   = (dig == 2'd0) ? pts[3:0] : (dig == 2'd1) ? pts[7:4] : 4'd0;
        s         = {1'b0, acc_dig} + {1'b0, pts_dig} + {4'd0, carry};
        s_minus10 = s - 5'd10;
        if (s > 5'd9) begin
            sum_dig   = s_minus10[3:0];
            carry_out = 1'b1;
        end else begin
            sum_dig   = s[3:0];
            carry_out = 1'b0;
        end
        acc_add = acc;
        acc_add[{dig, 2'b00} +: 4] = sum_dig;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_score) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = skip_add ? DONE : ADD;
                ADD:     if (last_dig && (carry_out || rep <= 4'd1)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        event_ready = (state == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= 16'h0000;
            score_bcd    <= 16'h0000;
            score_update <= 1'b0;
            saturated    <= 1'b0;
            pts          <= 8'h00;
            rep          <= 4'd0;
            dig          <= 2'd0;
            carry        <= 1'b0;
        end else if (clear_score) begin
            acc          <= 16'h0000;
            score_bcd    <= 16'h0000;
            score_update <= 1'b1;
            saturated    <= 1'b0;
            dig          <= 2'd0;
            carry        <= 1'b0;
        end else begin
            score_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pts   <= ev_pts;
                        rep   <= (level == 4'd0) ? 4'd1 : level;
                        dig   <= 2'd0;
                        carry <= 1'b0;
                        if (skip_add) score_update <= 1'b1;
                    end
                end
                ADD: begin
                    if (!last_dig) begin
                        acc   <= acc_add;
                        dig   <= dig + 2'd1;
                        carry <= carry_out;
                    end else if (carry_out) begin
                        acc          <= 16'h9999;
                        score_bcd    <= 16'h9999;
                        saturated    <= 1'b1;
                        score_update <= 1'b1;
                    end else if (rep > 4'd1) begin
                        // next repetition restarts at the ones digit with no carry in
                        acc   <= acc_add;
                        rep   <= rep - 4'd1;
                        dig   <= 2'd0;
                        carry <= 1'b0;
                    end else begin
                        acc          <= acc_add;
                        score_bcd    <= acc_add;
                        score_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Bench for score_bcd_accumulator: directed scenarios plus random events, checked
// against a decimal-integer score model with cycle-count latency expectations.
module tb_score_bcd_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        event_valid;
    logic        event_ready;
    logic [2:0]  clear_count;
    logic [3:0]  level;
    logic        clear_score;
    logic [15:0] score_bcd;
    logic        score_update;
    logic        saturated;

    int total  = 0;
    int passed = 0;
    int m_score = 0;
    bit m_sat   = 0;

    score_bcd_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .clear_count  (clear_count),
        .level        (level),
        .clear_score  (clear_score),
        .score_bcd    (score_bcd),
        .score_update (score_update),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int pts_of(input int cc);
        case (cc)
            1: return 1;
            2: return 3;
            3: return 5;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issues one event from a negedge in IDLE and checks the whole transaction.
    task automatic do_event(input int cc, input int lvl);
        int n, k, lvl_eff, pts;
        logic [15:0] old;
        bit moved, busy_bad;
        n = 0;
        while (event_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        pts = pts_of(cc);
        lvl_eff = (lvl == 0) ? 1 : lvl;
        k = 0;
        if (pts != 0 && !m_sat) begin
            for (int i = 0; i < lvl_eff && !m_sat; i++) begin
                k++;
                m_score += pts;
                if (m_score > 9999) begin m_score = 9999; m_sat = 1; end
            end
        end
        old = score_bcd;
        event_valid = 1'b1; clear_count = 3'(cc); level = 4'(lvl);
        @(posedge clk); #1;
        event_valid = 1'b0; clear_count = 3'($urandom); level = 4'($urandom);
        n = 0; moved = 0; busy_bad = 0;
        do begin
            @(negedge clk); n++;
            if (event_ready !== 1'b0) busy_bad = 1;
            if (score_update !== 1'b1 && score_bcd !== old) moved = 1;
        end while (score_update !== 1'b1 && n < 300);
        chk("latency", n, 4 * k + 1);
        chk("score", score_bcd, to_bcd(m_score));
        chk("saturated", saturated, m_sat);
        chk("no_partial", moved, 0);
        chk("busy_ready", busy_bad, 0);
        @(negedge clk);
        chk("update_pulse", score_update, 0);
        chk("ready_back", event_ready, 1);
    endtask

    task automatic do_clear();
        clear_score = 1'b1;
        @(posedge clk); #1;
        clear_score = 1'b0;
        @(negedge clk);
        m_score = 0; m_sat = 0;
        chk("clear_score_val", score_bcd, 16'h0000);
        chk("clear_update", score_update, 1);
        chk("clear_sat", saturated, 0);
        @(negedge clk);
    endtask

    initial begin
        int n, ups, rem, l;
        reset = 1'b1; event_valid = 1'b0; clear_count = 3'd0; level = 4'd0; clear_score = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_update", score_update, 0);
        chk("rst_sat", saturated, 0);
        chk("rst_ready", event_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // single line, level 1
        do_event(1, 1);
        chk("t1_score", score_bcd, 16'h0001);

        // build 0099 then a tetris carries through two digits
        do_clear();
        do_event(4, 12);
        do_event(2, 0);
        chk("t2_pre", score_bcd, 16'h0099);
        do_event(4, 1);
        chk("t2_carry", score_bcd, 16'h0107);

        // level 3 tetris, then level 0 double
        do_clear();
        do_event(4, 3);
        chk("t3_l3", score_bcd, 16'h0024);
        do_event(2, 0);
        chk("t3_l0", score_bcd, 16'h0027);

        // zero-point events
        do_event(0, 5);
        do_event(6, 9);
        do_event(7, 0);
        chk("t5_zero", score_bcd, 16'h0027);

        // valid held through busy: accepted once per IDLE window
        event_valid = 1'b1; clear_count = 3'd1; level = 4'd1;
        n = 0;
        do begin @(negedge clk); n++; end while (score_update !== 1'b1 && n < 50);
        chk("held_first", score_bcd, 16'h0028);
        @(negedge clk);
        chk("held_ready", event_ready, 1);
        @(posedge clk); #1;
        event_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (score_update !== 1'b1 && n < 50);
        chk("held_lat", n, 5);
        chk("held_second", score_bcd, 16'h0029);
        m_score = 29;
        ups = 0;
        repeat (10) begin @(negedge clk); if (score_update === 1'b1) ups++; end
        chk("held_once", ups, 0);

        // random events
        for (int i = 0; i < 40; i++) do_event($urandom_range(7, 0), $urandom_range(15, 0));

        // build 9995 then saturate
        do_clear();
        for (int i = 0; i < 83; i++) do_event(4, 15);
        rem = 9995 - m_score;
        while (rem > 0) begin
            l = (rem > 15) ? 15 : rem;
            do_event(1, l);
            rem -= l;
        end
        chk("t4_pre", score_bcd, 16'h9995);
        do_event(4, 1);
        chk("t4_sat_val", score_bcd, 16'h9999);
        chk("t4_sat_flag", saturated, 1);
        do_event(3, 7);
        chk("t4_stay", score_bcd, 16'h9999);

        // clear during ADD drops the event
        do_clear();
        do_event(4, 1);
        event_valid = 1'b1; clear_count = 3'd4; level = 4'd3;
        @(posedge clk); #1;
        event_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t6_busy", event_ready, 0);
        clear_score = 1'b1;
        @(posedge clk); #1;
        clear_score = 1'b0;
        @(negedge clk);
        m_score = 0; m_sat = 0;
        chk("t6_score", score_bcd, 16'h0000);
        chk("t6_update", score_update, 1);
        chk("t6_ready", event_ready, 1);
        ups = 0;
        repeat (15) begin @(negedge clk); if (score_update === 1'b1) ups++; end
        chk("t6_dropped", ups, 0);
        chk("t6_still0", score_bcd, 16'h0000);

        // clear with simultaneous valid in IDLE: not accepted
        clear_score = 1'b1; event_valid = 1'b1; clear_count = 3'd1; level = 4'd1;
        @(posedge clk); #1;
        clear_score = 1'b0; event_valid = 1'b0;
        @(negedge clk);
        chk("t6_sim_ready", event_ready, 1);
        @(negedge clk);
        chk("t6_sim_idle", event_ready, 1);
        chk("t6_sim_noupd", score_update, 0);

        // async reset mid-ADD
        do_event(4, 2);
        chk("t6_pre_rst", score_bcd, 16'h0016);
        event_valid = 1'b1; clear_count = 3'd4; level = 4'd4;
        @(posedge clk); #1;
        event_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_score", score_bcd, 16'h0000);
        chk("arst_update", score_update, 0);
        chk("arst_sat", saturated, 0);
        chk("arst_ready", event_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        m_score = 0; m_sat = 0;
        do_event(2, 2);
        chk("post_rst", score_bcd, 16'h0006);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
